// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : Shared constants and response record for the instruction
//               memory responder and its delay pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0), returned for out-of-range fetches
  localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

  // Deepest request-to-response latency the responder supports
  localparam int IMEM_LATENCY_MAX = 4;

  // One response slot travelling down the delay pipeline
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } imem_resp_t;

endpackage
`default_nettype wire

// File: rtl/imem_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : imem_delay_line
// Description : Fixed-depth shift pipeline of imem_resp_t records. An entry
//               written at the head appears at the tail LATENCY cycles later.
//               kill empties every stage already in flight while still
//               accepting the record arriving at the head that same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_delay_line
  import imem_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kill,
  input  imem_resp_t head,
  output imem_resp_t tail
);

  imem_resp_t stages [LATENCY];

  // Shift records toward the tail; cleared slots are all-zero so the
  // tail record carries zero data/addr/err whenever it is not valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= head;
      for (int i = 1; i < LATENCY; i++) begin
        stages[i] <= kill ? '0 : stages[i-1];
      end
    end
  end

  assign tail = stages[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : imem_responder
// Description : Fixed-latency instruction memory model. Accepts one fetch per
//               cycle with no backpressure, reads the array in the acceptance
//               cycle (read-before-write against the preload port) and
//               presents the word LATENCY cycles later, in order. flush kills
//               all older in-flight responses. The array is not reset.
//               Optional feature macro: IMEM_BOUNDS_CHECK_EN -- fetches beyond
//               MEM_WORDS return IMEM_NOP with err=1 and out-of-range loads are
//               dropped; otherwise addresses wrap modulo MEM_WORDS.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_responder
  import imem_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        proc2Imem_req,
  input  logic [31:0] proc2Imem_addr,
  input  logic        flush,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        Imem2proc_valid,
  output logic [31:0] Imem2proc_data,
  output logic [31:0] Imem2proc_addr,
  output logic        Imem2proc_err,
  output logic [2:0]  inflight_cnt
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [31:0]      mem [MEM_WORDS];
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] load_idx;
  logic             fetch_in_range;
  logic             load_in_range;
  imem_resp_t       head;
  imem_resp_t       tail;
  logic [2:0]       cnt;

  assign fetch_idx = proc2Imem_addr[IDX_W+1:2];
  assign load_idx  = load_addr[IDX_W+1:2];

`ifdef IMEM_BOUNDS_CHECK_EN
  // A word address is in range when no bit above the index field is set
  assign fetch_in_range = ((proc2Imem_addr[31:2] >> IDX_W) == 30'd0);
  assign load_in_range  = ((load_addr[31:2] >> IDX_W) == 30'd0);
`else
  // Addresses wrap modulo MEM_WORDS, so every address maps onto the array
  assign fetch_in_range = 1'b1;
  assign load_in_range  = 1'b1;
`endif

  // Byte-offset bits and (when wrapping) upper load address bits carry no
  // meaning; fold them together so they are visibly consumed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{proc2Imem_addr[1:0], load_addr[1:0], load_addr[31:IDX_W+2]};

  // Build the response record in the acceptance cycle; the array read is
  // combinational here so a same-cycle preload write is not yet visible.
  always_comb begin
    head = '0;
    if (proc2Imem_req && !rst) begin
      head.valid = 1'b1;
      head.addr  = {proc2Imem_addr[31:2], 2'b00};
      if (fetch_in_range) begin
        head.data = mem[fetch_idx];
      end else begin
        head.data = IMEM_NOP;
        head.err  = 1'b1;
      end
    end
  end

  // Preload port: array contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (!rst && load_en && load_in_range) begin
      mem[load_idx] <= load_data;
    end
  end

  imem_delay_line #(
    .LATENCY (LATENCY)
  ) u_delay_line (
    .clk  (clk),
    .rst  (rst),
    .kill (flush),
    .head (head),
    .tail (tail)
  );

  // Track accepted, unkilled, not-yet-presented requests; a flush leaves
  // only the request accepted in the flush cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 3'd0;
    end else if (flush) begin
      cnt <= {2'b00, head.valid};
    end else begin
      cnt <= cnt + {2'b00, head.valid} - {2'b00, tail.valid};
    end
  end

  assign Imem2proc_valid = tail.valid;
  assign Imem2proc_data  = tail.data;
  assign Imem2proc_addr  = tail.addr;
  assign Imem2proc_err   = tail.err;
  assign inflight_cnt    = cnt;

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_responder
// Description : Directed plus short random bench for imem_responder with a
//               reference memory and an in-order response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_responder;
  import imem_pkg::*;

  localparam int MEM_WORDS = 1024;
  localparam int LAT       = 2;

  logic        clk;
  logic        rst;
  logic        proc2Imem_req;
  logic [31:0] proc2Imem_addr;
  logic        flush;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        Imem2proc_valid;
  logic [31:0] Imem2proc_data;
  logic [31:0] Imem2proc_addr;
  logic        Imem2proc_err;
  logic [2:0]  inflight_cnt;

  imem_responder #(
    .MEM_WORDS (MEM_WORDS),
    .LATENCY   (LAT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .proc2Imem_req   (proc2Imem_req),
    .proc2Imem_addr  (proc2Imem_addr),
    .flush           (flush),
    .load_en         (load_en),
    .load_addr       (load_addr),
    .load_data       (load_data),
    .Imem2proc_valid (Imem2proc_valid),
    .Imem2proc_data  (Imem2proc_data),
    .Imem2proc_addr  (Imem2proc_addr),
    .Imem2proc_err   (Imem2proc_err),
    .inflight_cnt    (inflight_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mm [MEM_WORDS];
  int          cyc   = 0;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic in_range(input logic [31:0] a);
`ifdef IMEM_BOUNDS_CHECK_EN
    return (a[31:2] < MEM_WORDS);
`else
    return 1'b1;
`endif
  endfunction

  // Drive one cycle, update the reference model, advance, then compare.
  task automatic step(input logic rq, input logic [31:0] a, input logic fl,
                      input logic ld, input logic [31:0] la, input logic [31:0] lv,
                      input logic rs);
    exp_t e;
    logic do_wr;
    proc2Imem_req  = rq;
    proc2Imem_addr = a;
    flush          = fl;
    load_en        = ld;
    load_addr      = la;
    load_data      = lv;
    rst            = rs;
    do_wr          = 1'b0;
    if (rs) begin
      sb.delete();
    end else begin
      if (fl) sb.delete();
      if (rq) begin
        e.addr = {a[31:2], 2'b00};
        e.err  = !in_range(a);
        e.data = e.err ? IMEM_NOP : mm[a[11:2]];
        e.due  = cyc + LAT;
        sb.push_back(e);
      end
      if (ld && in_range(la)) do_wr = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (do_wr) mm[la[11:2]] = lv;
    check("inflight_cnt", {29'd0, inflight_cnt}, sb.size());
    if (sb.size() > 0 && sb[0].due == cyc) begin
      check("valid", {31'd0, Imem2proc_valid}, 32'd1);
      check("data",  Imem2proc_data, sb[0].data);
      check("addr",  Imem2proc_addr, sb[0].addr);
      check("err",   {31'd0, Imem2proc_err}, {31'd0, sb[0].err});
      void'(sb.pop_front());
    end else begin
      check("idle_valid", {31'd0, Imem2proc_valid}, 32'd0);
      check("idle_data",  Imem2proc_data, 32'd0);
      check("idle_addr",  Imem2proc_addr, 32'd0);
      check("idle_err",   {31'd0, Imem2proc_err}, 32'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fetch(input logic [31:0] a);
    step(1, a, 0, 0, 0, 0, 0);
  endtask

  task automatic load(input logic [31:0] la, input logic [31:0] lv);
    step(0, 0, 0, 1, la, lv, 0);
  endtask

  initial begin
    logic [31:0] iv;
    logic [31:0] ra;
    for (int i = 0; i < MEM_WORDS; i++) mm[i] = 32'd0;

    // Reset: outputs and counter zero; loads and requests during rst ignored
    step(1, 32'h0, 0, 1, 32'h0, 32'hFFFF_FFFF, 1);
    step(0, 32'h0, 1, 0, 32'h0, 32'h0, 1);

    // Preload whole array with a distinct pattern
    for (int i = 0; i < MEM_WORDS; i++) begin
      iv = i;
      load(iv << 2, (iv * 32'h9E37_79B9) ^ 32'h5A5A_0000);
    end

    // Load during reset must not land
    step(0, 0, 0, 1, 32'h30, 32'h0000_0BAD, 1);
    fetch(32'h30);
    idle(3);

    // Basic fetch of a preloaded word (word 0x10)
    load(32'h40, 32'hDEAD_BEEF);
    idle(1);
    fetch(32'h40);
    idle(3);

    // Back-to-back requests
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    idle(4);

    // Flush kills the older request, the same-cycle one survives
    fetch(32'h0);
    step(1, 32'h100, 1, 0, 0, 0, 0);
    idle(4);

    // Read-before-write on same word, then new value visible
    load(32'h20, 32'h2222_2222);
    idle(1);
    step(1, 32'h20, 0, 1, 32'h20, 32'h1111_1111, 0);
    idle(3);
    fetch(32'h20);
    idle(3);

    // Reset with requests in flight; array survives
    fetch(32'h4);
    fetch(32'h8);
    step(1, 32'hC, 0, 0, 0, 0, 1);
    idle(3);
    fetch(32'h40);
    idle(3);

    // Reset has priority over flush; flush with no request empties pipe
    fetch(32'h10);
    step(1, 32'h14, 1, 0, 0, 0, 1);
    idle(2);
    fetch(32'h18);
    step(0, 0, 1, 0, 0, 0, 0);
    idle(3);

    // Address beyond MEM_WORDS: wraps or returns NOP/err depending on build
    load(32'h0, 32'hCAFE_F00D);
    fetch(32'h1000);
    step(0, 0, 0, 1, 32'h1004, 32'h7777_7777, 0);
    fetch(32'h4);
    fetch(32'hFFFF_FFFC);
    idle(3);

    // Short random mix of traffic
    for (int i = 0; i < 60; i++) begin
      ra = {20'd0, 10'($urandom_range(0, MEM_WORDS - 1)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) ra = ra | 32'h0000_1000;
      step(1'($urandom_range(0, 1)), ra,
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) == 0), {20'd0, 10'($urandom_range(0, MEM_WORDS - 1)), 2'b00},
           $urandom, ($urandom_range(0, 29) == 0));
    end
    idle(LAT + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
